// File: rtl/load_store_unit_pkg.sv
// Shared RISC-V datapath definitions: bus widths, access-size encoding and
// the load/store unit state enum. Imported by every file of the LSU.
package load_store_unit_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef logic [1:0] mem_size_t;

    localparam mem_size_t MEM_SIZE_BYTE = 2'b00;
    localparam mem_size_t MEM_SIZE_HALF = 2'b01;
    localparam mem_size_t MEM_SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lsu_state_t;

    // Number of bytes touched by an access; 0 marks the reserved encoding.
    function automatic logic [2:0] size_bytes(input mem_size_t size);
        case (size)
            MEM_SIZE_BYTE: size_bytes = 3'd1;
            MEM_SIZE_HALF: size_bytes = 3'd2;
            MEM_SIZE_WORD: size_bytes = 3'd4;
            default:       size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_addr_check.sv
// Combinational legality check for one LSU request: size encoding, memory
// range and (when LSU_MISALIGN_TRAP_EN is defined) natural alignment.
module lsu_addr_check
    import load_store_unit_pkg::*;
#(
    parameter int MEM_BYTES = 4096
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  mem_size_t             size,
    output logic                  legal
);

    logic                size_err;
    logic                range_err;
    logic                align_err;
    logic [ADDR_WIDTH:0] last_byte;

    always_comb begin
        size_err  = (size == 2'b11);
        // One extra bit so an access near the top of the address space
        // cannot wrap around and look in range.
        last_byte = {1'b0, addr} + (ADDR_WIDTH + 1)'(size_bytes(size))
                    - (ADDR_WIDTH + 1)'(1);
        range_err = (last_byte >= (ADDR_WIDTH + 1)'(MEM_BYTES));
`ifdef LSU_MISALIGN_TRAP_EN
        align_err = ((size == MEM_SIZE_HALF) && addr[0]) ||
                    ((size == MEM_SIZE_WORD) && (addr[1:0] != 2'b00));
`else
        align_err = 1'b0;
`endif
        legal     = !(size_err || range_err || align_err);
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE -> ACCESS -> RESP handshake in
// front of a byte-addressed data memory. Optional LSU_MISALIGN_TRAP_EN.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MEM_BYTES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  mem_size_t             req_size,
    input  logic                  req_sign,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output mem_size_t             mem_size,
    output logic                  mem_sign,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    lsu_state_t            state, state_next;
    logic                  req_legal;

    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    mem_size_t             size_q;
    logic                  sign_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    lsu_addr_check #(
        .MEM_BYTES(MEM_BYTES)
    ) u_addr_check (
        .addr (req_addr),
        .size (req_size),
        .legal(req_legal)
    );

    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: defaults first so every path assigns state_next (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = req_legal ? ACCESS : RESP;
            ACCESS:  state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= MEM_SIZE_BYTE;
            sign_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    size_q  <= req_size;
                    sign_q  <= req_sign;
                    rdata_q <= '0;
                    err_q   <= !req_legal;
                end
                ACCESS: begin
                    rdata_q <= we_q ? '0 : mem_rdata;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Gated with rst_n so a reset landing on the ACCESS edge suppresses the write.
    assign mem_we    = (state == ACCESS) && we_q && rst_n;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_size  = size_q;
    assign mem_sign  = sign_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: behavioural byte memory, vector
// table with response scoreboard, plus backpressure/reset/misalign sequences.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  req_valid, req_ready, req_we, req_sign;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    mem_size_t             req_size;
    logic                  resp_valid, resp_ready, resp_err;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  mem_we, mem_sign;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;
    mem_size_t             mem_size;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(4096)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_sign(req_sign), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_sign(mem_sign), .mem_rdata(mem_rdata)
    );

    // Byte-addressed memory: little-endian, performs size/sign extension on reads.
    logic [7:0]  mem [0:4095];
    int          wr_count = 0;
    logic [11:0] a0;
    logic [7:0]  b0, b1, b2, b3;

    initial for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

    always @(posedge clk) begin
        if (mem_we) begin
            wr_count <= wr_count + 1;
            mem[mem_addr[11:0]] <= mem_wdata[7:0];
            if (mem_size != MEM_SIZE_BYTE) mem[mem_addr[11:0] + 12'd1] <= mem_wdata[15:8];
            if (mem_size == MEM_SIZE_WORD) begin
                mem[mem_addr[11:0] + 12'd2] <= mem_wdata[23:16];
                mem[mem_addr[11:0] + 12'd3] <= mem_wdata[31:24];
            end
        end
    end

    always_comb begin
        a0 = mem_addr[11:0];
        b0 = mem[a0];
        b1 = mem[a0 + 12'd1];
        b2 = mem[a0 + 12'd2];
        b3 = mem[a0 + 12'd3];
        case (mem_size)
            MEM_SIZE_BYTE: mem_rdata = {{24{mem_sign & b0[7]}}, b0};
            MEM_SIZE_HALF: mem_rdata = {{16{mem_sign & b1[7]}}, b1, b0};
            default:       mem_rdata = {b3, b2, b1, b0};
        endcase
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_size  = v.size;
        req_sign  = v.sign;
        sb.push_back('{v.exp_rdata, v.exp_err});
    endtask

    task automatic pop_compare(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, " sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({name, " rdata"}, resp_rdata, e.rdata);
        check({name, " err"}, {31'd0, resp_err}, {31'd0, e.err});
    endtask

    // Entered and left at a negedge with the DUT in IDLE and resp_ready=1.
    task automatic run_req(input string name, input vec_t v);
        int lat;
        check({name, " req_ready"}, {31'd0, req_ready}, 32'd1);
        drive(v);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, lat, v.exp_err ? 32'd1 : 32'd2);
        pop_compare(name);
        @(negedge clk);
    endtask

    vec_t vec[13];
    vec_t v;
    int   wr_before;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_size = MEM_SIZE_BYTE; req_sign = 1'b0; resp_ready = 1'b1;

        //        we    addr           wdata          size  sign  exp_rdata      err
        vec[0]  = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'h0000_0000, 1'b0};
        vec[1]  = '{1'b0, 32'h0000_0100, 32'h0,         2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0};
        vec[2]  = '{1'b0, 32'h0000_0103, 32'h0,         2'd0, 1'b1, 32'hFFFF_FFDE, 1'b0};
        vec[3]  = '{1'b0, 32'h0000_0102, 32'h0,         2'd1, 1'b0, 32'h0000_DEAD, 1'b0};
        vec[4]  = '{1'b0, 32'h0000_0101, 32'h0,         2'd0, 1'b0, 32'h0000_00BE, 1'b0};
        vec[5]  = '{1'b0, 32'h0000_0100, 32'h0,         2'd1, 1'b1, 32'hFFFF_BEEF, 1'b0};
        vec[6]  = '{1'b0, 32'h0000_0FFE, 32'h0,         2'd2, 1'b0, 32'h0000_0000, 1'b1};
        vec[7]  = '{1'b0, 32'h0000_0FFC, 32'h0,         2'd2, 1'b0, 32'h0000_0000, 1'b0};
        vec[8]  = '{1'b0, 32'h0000_0100, 32'h0,         2'd3, 1'b0, 32'h0000_0000, 1'b1};
        vec[9]  = '{1'b0, 32'h0000_1000, 32'h0,         2'd0, 1'b0, 32'h0000_0000, 1'b1};
        vec[10] = '{1'b1, 32'h0000_0FFE, 32'h1234_ABCD, 2'd1, 1'b0, 32'h0000_0000, 1'b0};
        vec[11] = '{1'b0, 32'h0000_0FFE, 32'h0,         2'd1, 1'b1, 32'hFFFF_ABCD, 1'b0};
        vec[12] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         2'd2, 1'b0, 32'h0000_0000, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst req_ready",  {31'd0, req_ready},  32'd1);
        check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst resp_rdata", resp_rdata, 32'd0);
        check("rst resp_err",   {31'd0, resp_err},   32'd0);
        check("rst mem_we",     {31'd0, mem_we},     32'd0);
        check("rst mem_addr",   mem_addr, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) run_req($sformatf("vec%0d", i), vec[i]);

        // Backpressure: response held for 5 cycles with resp_ready low
        resp_ready = 1'b0;
        drive('{1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0});
        @(negedge clk);
        req_valid = 1'b0;
        check("bp access no_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d resp_valid", i), {31'd0, resp_valid}, 32'd1);
            check($sformatf("bp%0d resp_rdata", i), resp_rdata, 32'hDEAD_BEEF);
            check($sformatf("bp%0d req_ready", i),  {31'd0, req_ready},  32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        pop_compare("bp");
        @(negedge clk);
        check("bp released resp_valid", {31'd0, resp_valid}, 32'd0);
        check("bp released req_ready",  {31'd0, req_ready},  32'd1);

        // Reset during ACCESS of a store: no write, response discarded
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h200;
        req_wdata = 32'h5555_AAAA; req_size = MEM_SIZE_WORD; req_sign = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstacc in_access", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstacc resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rstacc req_ready",  {31'd0, req_ready},  32'd1);
        check("rstacc mem_we",     {31'd0, mem_we},     32'd0);
        check("rstacc mem200", {mem[12'h203], mem[12'h202], mem[12'h201], mem[12'h200]}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_req("rstacc load200", '{1'b0, 32'h200, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0});

        // Misaligned word store at 0x102
        wr_before = wr_count;
`ifdef LSU_MISALIGN_TRAP_EN
        run_req("mis store", '{1'b1, 32'h102, 32'hCAFE_F00D, 2'd2, 1'b0, 32'h0, 1'b1});
        check("mis no_write", wr_count - wr_before, 32'd0);
        run_req("mis reload", '{1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0});
`else
        run_req("mis store", '{1'b1, 32'h102, 32'hCAFE_F00D, 2'd2, 1'b0, 32'h0, 1'b0});
        check("mis one_write", wr_count - wr_before, 32'd1);
        run_req("mis reload", '{1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 32'hF00D_BEEF, 1'b0});
`endif

        check("sb drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_BYTES, default 4096, is the data memory size in bytes and sets the legal address range 0..MEM_BYTES-1.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 Port req_valid, input, 1 bit: pipeline presents a memory request.
REQ-005 Port req_ready, output, 1 bit: unit can accept a request this cycle.
REQ-006 Port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 Port req_addr, input, ADDR_WIDTH bits: byte address.
REQ-008 Port req_wdata, input, DATA_WIDTH bits: store data, right-aligned.
REQ-009 Port req_size, input, mem_size_t: access size (byte, halfword or word).
REQ-010 Port req_sign, input, 1 bit: load sign-extension select.
REQ-011 Port resp_valid, output, 1 bit: response available.
REQ-012 Port resp_ready, input, 1 bit: pipeline consumes the response.
REQ-013 Port resp_rdata, output, DATA_WIDTH bits: load result; 0 for stores and errors.
REQ-014 Port resp_err, output, 1 bit: access fault (misaligned, out-of-range or illegal size).
REQ-015 Ports mem_we (output, 1), mem_addr (output, ADDR_WIDTH), mem_wdata (output, DATA_WIDTH), mem_size (output, mem_size_t), mem_sign (output, 1) and mem_rdata (input, DATA_WIDTH) connect directly to the data memory.

Function
REQ-016 FSM states: IDLE, ACCESS, RESP; req_ready shall be 1 only in IDLE.
REQ-017 IDLE with req_valid=1: latch we/addr/wdata/size/sign; go to ACCESS if the request is legal, otherwise go to RESP with resp_err=1.
REQ-018 Illegal request conditions: req_size=2'b11; or addr+bytes-1 >= MEM_BYTES, computed one bit wider than ADDR_WIDTH so there is no wrap-around; or misaligned when trap is enabled (see Configuration).
REQ-019 ACCESS lasts exactly one cycle; mem_addr/mem_size/mem_sign/mem_wdata are driven from latched values, and mem_we = latched we.
REQ-020 mem_we shall be 0 in every state other than ACCESS; a faulting store shall never write memory.
REQ-021 At the end of ACCESS, resp_rdata is captured from mem_rdata for loads (0 for stores), resp_err=0, and the FSM goes to RESP.
REQ-022 In RESP, resp_valid=1 and resp_rdata/resp_err are held stable until resp_ready=1; the FSM then returns to IDLE.
REQ-023 If resp_ready=1 in the same cycle resp_valid first rises, the FSM returns to IDLE on the next edge; a new request is accepted no earlier than the cycle after RESP.
REQ-024 Load latency: the request is accepted at edge N, memory is read during cycle N+1, and resp_valid=1 in cycle N+2. Peak throughput is one access per 3 cycles.
REQ-025 Outside ACCESS, mem_addr/mem_size/mem_sign/mem_wdata shall hold their last latched values.

Reset
REQ-026 When rst_n=0 at a clock edge: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, and all latched request fields=0.
REQ-027 Reset asserted during ACCESS or RESP shall discard the pending response, and no write shall occur after that edge.

Configuration
REQ-028 Macro LSU_MISALIGN_TRAP_EN defined: a halfword at an odd address, or a word at an address with addr[1:0]!=0, shall be faulted with resp_err=1 and no memory access.
REQ-029 Macro LSU_MISALIGN_TRAP_EN undefined: misaligned accesses shall be passed to the byte-addressed memory unchanged; only size and range faults remain.

Structure
REQ-030 ADDR_WIDTH, DATA_WIDTH, mem_size_t and the MEM_SIZE_* constants shall come from the shared _riscv_defines package; the LSU FSM state enum shall be added to that package.
REQ-031 A single sub-module lsu_addr_check shall be used: a combinational legality check (size, range, alignment) taking addr, size and MEM_BYTES.

Verification
REQ-032 Store a word 0xDEADBEEF at 0x100, then load a word at 0x100 -> resp_rdata=0xDEADBEEF, resp_err=0, with resp_valid 2 cycles after acceptance.
REQ-033 After REQ-032, load a signed byte at 0x103 -> 0xFFFFFFDE; load an unsigned halfword at 0x102 -> 0x0000DEAD.
REQ-034 With the macro defined, store a word at 0x102 -> resp_err=1, mem_we never 1, and memory at 0x100 still reads 0xDEADBEEF; with the macro undefined, the same store succeeds.
REQ-035 Load a word at 0xFFE with MEM_BYTES=4096 -> resp_err=1; load a word at 0xFFC -> resp_err=0.
REQ-036 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stable and req_ready=0 throughout; resp_ready=1 -> IDLE on the next cycle.
REQ-037 Assert rst_n=0 in ACCESS of a store to 0x200 -> next cycle state is IDLE, resp_valid=0, and memory at 0x200 reads 0.
